// File: rtl/rx_pkg.sv
// Shared receive-path definitions.
// Holds the K28.5 comma codes (both running disparities), the symbol
// width and the alignment state encoding used by the word aligner.
package rx_pkg;

  localparam int SYM_W = 10;

  // K28.5 as transmitted, bit a first (bit a sits at [9]).
  localparam logic [SYM_W-1:0] K285_RDN = 10'b0011111010;
  localparam logic [SYM_W-1:0] K285_RDP = 10'b1100000101;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/comma_match.sv
// Combinational K28.5 detector.
// Ports:
//   window_i  in  SYM_W : 10-bit candidate symbol, bit a at [9]
//   match_o   out 1     : window is K28.5 of either running disparity
module comma_match
  import rx_pkg::*;
(
  input  logic [SYM_W-1:0] window_i,
  output logic             match_o
);

  assign match_o = (window_i == K285_RDN) || (window_i == K285_RDP);

endmodule

// File: rtl/deser_align.sv
// Serial-to-parallel word aligner with comma-based lock FSM.
// Shifts the recovered bit stream in, snaps the 10-bit word boundary to
// any K28.5 seen while hunting/checking, and reports lock with hysteresis.
// Parameters:
//   LOCK_COMMAS : on-boundary commas (including the realigning one) to lock
//   LOSS_COMMAS : consecutive off-boundary commas in LOCKED that force realign
// Ports:
//   CRCLK        in  1     : recovered bit clock
//   Reset_n      in  1     : asynchronous active-low reset
//   serial_in    in  1     : serial data, bit a of each symbol first
//   data_out     out SYM_W : last complete symbol, bit a at [9], bit j at [0]
//   word_strobe  out 1     : pulses in the cycle data_out takes a new value
//   comma_out    out 1     : data_out holds K28.5
//   aligned      out 1     : high while LOCKED
module deser_align
  import rx_pkg::*;
#(
  parameter int LOCK_COMMAS = 3,
  parameter int LOSS_COMMAS = 2
) (
  input  logic             CRCLK,
  input  logic             Reset_n,
  input  logic             serial_in,
  output logic [SYM_W-1:0] data_out,
  output logic             word_strobe,
  output logic             comma_out,
  output logic             aligned
);

  localparam int CW = $clog2(max_int(LOCK_COMMAS, LOSS_COMMAS) + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_COMMAS);
  localparam logic [CW-1:0] LOSS_MAX = CW'(LOSS_COMMAS);
  localparam logic [CW-1:0] ONE      = CW'(1);

  // Only nine history bits are kept: the live serial bit completes the
  // window, so the oldest shifted bit would never be looked at.
  logic [SYM_W-2:0] sr_q;
  logic [3:0]       cnt_q, cnt_d;
  logic [CW-1:0]    good_q, good_d;
  logic [CW-1:0]    mis_q, mis_d;
  align_state_t     state_q, state_d;

  logic [SYM_W-1:0] window;
  logic             comma;
  logic             boundary;
  logic             realign;

  assign window   = {sr_q, serial_in};
  assign boundary = (cnt_q == 4'd9);

  comma_match u_comma_match (
    .window_i (window),
    .match_o  (comma)
  );

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    mis_d   = mis_q;
    realign = 1'b0;

    case (state_q)
      HUNT: begin
        // A comma on the free-running boundary is also a realign; the
        // result is identical to a plain boundary with cnt cleared.
        if (comma) begin
          realign = 1'b1;
          state_d = (LOCK_COMMAS == 1) ? LOCKED : CHECK;
        end
      end
      CHECK: begin
        if (comma && boundary) begin
          if (good_q != LOCK_MAX) good_d = good_q + ONE;
          if (good_q >= LOCK_MAX - ONE) state_d = LOCKED;
        end else if (comma) begin
          realign = 1'b1;
        end
      end
      LOCKED: begin
        if (comma && boundary) begin
          mis_d = '0;
        end else if (comma) begin
          // Tolerate isolated slips; only a run of off-boundary commas
          // moves the boundary.
          if (mis_q >= LOSS_MAX - ONE) begin
            realign = 1'b1;
            state_d = CHECK;
          end else begin
            mis_d = mis_q + ONE;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    // cnt = 0 after the edge makes this cycle the word boundary.
    if (realign) begin
      good_d = ONE;
      mis_d  = '0;
      cnt_d  = 4'd0;
    end else begin
      cnt_d  = boundary ? 4'd0 : cnt_q + 4'd1;
    end
  end

  always_ff @(posedge CRCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      sr_q        <= '0;
      cnt_q       <= 4'd0;
      good_q      <= '0;
      mis_q       <= '0;
      state_q     <= HUNT;
      data_out    <= '0;
      word_strobe <= 1'b0;
      comma_out   <= 1'b0;
      aligned     <= 1'b0;
    end else begin
      sr_q        <= window[SYM_W-2:0];
      cnt_q       <= cnt_d;
      good_q      <= good_d;
      mis_q       <= mis_d;
      state_q     <= state_d;
      word_strobe <= boundary || realign;
      if (boundary || realign) begin
        data_out  <= window;
        comma_out <= comma;
      end
      aligned     <= (state_d == LOCKED);
    end
  end

endmodule

// File: tb/tb_deser_align.sv
// Bench for deser_align: a default build (lock 3 / loss 2) and a lock-1
// build share one serial stream and are both checked every cycle against
// a bit-queue reference model, plus scenario-specific spot checks.
module tb_deser_align;

  localparam logic [9:0] RDN  = 10'h0FA;
  localparam logic [9:0] RDP  = 10'h305;
  localparam logic [9:0] DW   = 10'h2AA;
  localparam int         LOSS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sin = 1'b0;
  logic [9:0] dout0, dout1;
  logic       ws0, ws1, co0, co1, al0, al1;
  logic [12:0] obs0, obs1;

  int n_vec = 0;
  int n_err = 0;

  deser_align #(.LOCK_COMMAS(3), .LOSS_COMMAS(2)) dut0 (
    .CRCLK(clk), .Reset_n(rst_n), .serial_in(sin),
    .data_out(dout0), .word_strobe(ws0), .comma_out(co0), .aligned(al0)
  );

  deser_align #(.LOCK_COMMAS(1), .LOSS_COMMAS(2)) dut1 (
    .CRCLK(clk), .Reset_n(rst_n), .serial_in(sin),
    .data_out(dout1), .word_strobe(ws1), .comma_out(co1), .aligned(al1)
  );

  always #5 clk = ~clk;

  assign obs0 = {al0, ws0, co0, dout0};
  assign obs1 = {al1, ws1, co1, dout1};

  // ---------------- reference model ----------------
  bit         hist[$];
  int         m_lock[2] = '{3, 1};
  int         m_state[2];   // 0 hunting, 1 checking, 2 locked
  int         m_bits[2];    // bits collected since the last word boundary
  int         m_good[2];
  int         m_miss[2];
  logic [9:0] m_data[2];
  logic       m_comma[2];
  logic       m_strobe[2];
  logic       m_aligned[2];
  bit         stim[$];

  task automatic model_reset();
    hist.delete();
    repeat (9) hist.push_back(1'b0);
    for (int m = 0; m < 2; m++) begin
      m_state[m] = 0; m_bits[m] = 0; m_good[m] = 0; m_miss[m] = 0;
      m_data[m] = '0; m_comma[m] = 0; m_strobe[m] = 0; m_aligned[m] = 0;
    end
  endtask

  task automatic model_step(input bit b);
    logic [9:0] w;
    bit c, tenth, re;
    hist.push_back(b);
    if (hist.size() > 10) hist.delete(0);
    for (int i = 0; i < 10; i++) w[9-i] = hist[i];
    c = (w == RDN) || (w == RDP);
    for (int m = 0; m < 2; m++) begin
      tenth = (m_bits[m] == 9);
      re = 0;
      if (m_state[m] == 0) begin
        if (c) begin re = 1; m_state[m] = (m_lock[m] == 1) ? 2 : 1; end
      end else if (m_state[m] == 1) begin
        if (c && tenth) begin
          if (m_good[m] < m_lock[m]) m_good[m]++;
          if (m_good[m] >= m_lock[m]) m_state[m] = 2;
        end else if (c) re = 1;
      end else begin
        if (c && tenth) m_miss[m] = 0;
        else if (c) begin
          m_miss[m]++;
          if (m_miss[m] >= LOSS) begin re = 1; m_state[m] = 1; end
        end
      end
      if (re) begin m_good[m] = 1; m_miss[m] = 0; m_bits[m] = 0; end
      else m_bits[m] = tenth ? 0 : m_bits[m] + 1;
      m_strobe[m] = tenth || re;
      if (m_strobe[m]) begin m_data[m] = w; m_comma[m] = c; end
      m_aligned[m] = (m_state[m] == 2);
    end
  endtask

  function automatic logic [12:0] exp_vec(input int m);
    return {m_aligned[m], m_strobe[m], m_comma[m], m_data[m]};
  endfunction

  function automatic void add_word(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) stim.push_back(w[i]);
  endfunction

  task automatic step(input bit b);
    sin = b;
    @(posedge clk);
    if (rst_n) model_step(b);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    sin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (obs0 !== 13'h0) begin n_err++; $display("FAIL reset dut0: got %h want 0", obs0); end
    n_vec++;
    if (obs1 !== 13'h0) begin n_err++; $display("FAIL reset dut1: got %h want 0", obs1); end
    model_reset();
    rst_n = 1'b1;
    $display("test_reset: outputs checked in reset");
  endtask

  task automatic test_idle();
    int first_ws = -1;
    int n_ws = 0;
    stim.delete();
    repeat (40) stim.push_back(1'b0);
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      n_vec++;
      if (obs0 !== exp_vec(0)) begin n_err++; $display("FAIL idle cyc %0d dut0: got %h want %h", i, obs0, exp_vec(0)); end
      n_vec++;
      if (obs1 !== exp_vec(1)) begin n_err++; $display("FAIL idle cyc %0d dut1: got %h want %h", i, obs1, exp_vec(1)); end
      if (ws0) begin n_ws++; if (first_ws < 0) first_ws = i; end
    end
    n_vec++;
    if (first_ws !== 9) begin n_err++; $display("FAIL idle_first_strobe: got %0d want 9", first_ws); end
    n_vec++;
    if (n_ws !== 4) begin n_err++; $display("FAIL idle_strobe_count: got %0d want 4", n_ws); end
    $display("test_idle: 40 zero bits, %0d strobes", n_ws);
  endtask

  task automatic test_lock();
    stim.delete();
    stim.push_back(1'b1); stim.push_back(1'b1); stim.push_back(1'b0);
    add_word(RDN); add_word(DW); add_word(RDN); add_word(DW); add_word(RDN);
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      n_vec++;
      if (obs0 !== exp_vec(0)) begin n_err++; $display("FAIL lock cyc %0d dut0: got %h want %h", i, obs0, exp_vec(0)); end
      n_vec++;
      if (obs1 !== exp_vec(1)) begin n_err++; $display("FAIL lock cyc %0d dut1: got %h want %h", i, obs1, exp_vec(1)); end
      if (i == 12) begin
        n_vec++;
        if ({ws0, co0, dout0, al0} !== {1'b1, 1'b1, RDN, 1'b0}) begin
          n_err++; $display("FAIL lock_first_comma: got ws%b co%b %h al%b want ws1 co1 0fa al0", ws0, co0, dout0, al0);
        end
        n_vec++;
        if (al1 !== 1'b1) begin n_err++; $display("FAIL lock1_first_comma aligned: got %b want 1", al1); end
      end
      if (i == 51) begin
        n_vec++;
        if (al0 !== 1'b0) begin n_err++; $display("FAIL lock_before_third: got %b want 0", al0); end
      end
      if (i == 52) begin
        n_vec++;
        if (al0 !== 1'b1) begin n_err++; $display("FAIL lock_third_comma: got %b want 1", al0); end
      end
    end
    $display("test_lock: junk + 3 RD- commas, aligned=%b", al0);
  endtask

  task automatic test_slip();
    stim.delete();
    add_word(DW); stim.push_back(1'b0);
    add_word(RDN); add_word(DW); add_word(RDN);
    add_word(DW); add_word(RDN); add_word(DW); add_word(RDN);
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      n_vec++;
      if (obs0 !== exp_vec(0)) begin n_err++; $display("FAIL slip cyc %0d dut0: got %h want %h", i, obs0, exp_vec(0)); end
      n_vec++;
      if (obs1 !== exp_vec(1)) begin n_err++; $display("FAIL slip cyc %0d dut1: got %h want %h", i, obs1, exp_vec(1)); end
      if (i == 20) begin
        n_vec++;
        if ({ws0, al0} !== 2'b01) begin n_err++; $display("FAIL slip_single: got ws%b al%b want ws0 al1", ws0, al0); end
      end
      if (i == 40) begin
        n_vec++;
        if ({ws0, dout0, al0} !== {1'b1, RDN, 1'b0}) begin
          n_err++; $display("FAIL slip_loss_realign: got ws%b %h al%b want ws1 0fa al0", ws0, dout0, al0);
        end
      end
      if (i == 60) begin
        n_vec++;
        if (al0 !== 1'b0) begin n_err++; $display("FAIL slip_check_good2: got %b want 0", al0); end
      end
      if (i == 80) begin
        n_vec++;
        if (al0 !== 1'b1) begin n_err++; $display("FAIL slip_relock: got %b want 1", al0); end
      end
    end
    $display("test_slip: single slip tolerated, double slip realigned, relock aligned=%b", al0);
  endtask

  task automatic test_alt_disparity();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    stim.delete();
    stim.push_back(1'b0); stim.push_back(1'b1); stim.push_back(1'b0);
    add_word(RDP); add_word(DW); add_word(RDN); add_word(DW); add_word(RDP);
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      n_vec++;
      if (obs0 !== exp_vec(0)) begin n_err++; $display("FAIL alt cyc %0d dut0: got %h want %h", i, obs0, exp_vec(0)); end
      n_vec++;
      if (obs1 !== exp_vec(1)) begin n_err++; $display("FAIL alt cyc %0d dut1: got %h want %h", i, obs1, exp_vec(1)); end
      if (i == 12 || i == 52) begin
        n_vec++;
        if ({ws0, co0, dout0} !== {1'b1, 1'b1, RDP}) begin
          n_err++; $display("FAIL alt_rdp cyc %0d: got ws%b co%b %h want ws1 co1 305", i, ws0, co0, dout0);
        end
      end
      if (i == 32) begin
        n_vec++;
        if ({ws0, co0, dout0} !== {1'b1, 1'b1, RDN}) begin
          n_err++; $display("FAIL alt_rdn: got ws%b co%b %h want ws1 co1 0fa", ws0, co0, dout0);
        end
      end
      if (i == 52) begin
        n_vec++;
        if (al0 !== 1'b1) begin n_err++; $display("FAIL alt_lock: got %b want 1", al0); end
      end
    end
    $display("test_alt_disparity: RD+/RD-/RD+ commas, aligned=%b", al0);
  endtask

  task automatic test_async_reset();
    int first_ws = -1;
    for (int i = 0; i < 4; i++) begin
      step(DW[9-i]);
      n_vec++;
      if (obs0 !== exp_vec(0)) begin n_err++; $display("FAIL arst_pre cyc %0d dut0: got %h want %h", i, obs0, exp_vec(0)); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs0 !== 13'h0) begin n_err++; $display("FAIL arst_immediate dut0: got %h want 0", obs0); end
    n_vec++;
    if (obs1 !== 13'h0) begin n_err++; $display("FAIL arst_immediate dut1: got %h want 0", obs1); end
    model_reset();
    step(1'b1);
    step(1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step(1'b0);
      n_vec++;
      if (obs0 !== exp_vec(0)) begin n_err++; $display("FAIL arst_post cyc %0d dut0: got %h want %h", i, obs0, exp_vec(0)); end
      n_vec++;
      if (obs1 !== exp_vec(1)) begin n_err++; $display("FAIL arst_post cyc %0d dut1: got %h want %h", i, obs1, exp_vec(1)); end
      if (ws0 && first_ws < 0) first_ws = i;
    end
    n_vec++;
    if (first_ws !== 9) begin n_err++; $display("FAIL arst_first_strobe: got %0d want 9", first_ws); end
    $display("test_async_reset: mid-word reset cleared outputs, hunt resumed");
  endtask

  task automatic test_random();
    logic [9:0] w;
    stim.delete();
    for (int k = 0; k < 70; k++) begin
      case ($urandom_range(0, 5))
        0: add_word(RDN);
        1: add_word(RDP);
        2: begin
          repeat ($urandom_range(1, 3)) stim.push_back(1'($urandom_range(0, 1)));
          add_word(($urandom_range(0, 1) != 0) ? RDN : RDP);
        end
        default: begin
          w = 10'($urandom);
          add_word(w);
        end
      endcase
    end
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      n_vec++;
      if (obs0 !== exp_vec(0)) begin n_err++; $display("FAIL rand cyc %0d dut0: got %h want %h", i, obs0, exp_vec(0)); end
      n_vec++;
      if (obs1 !== exp_vec(1)) begin n_err++; $display("FAIL rand cyc %0d dut1: got %h want %h", i, obs1, exp_vec(1)); end
    end
    $display("test_random: %0d random bits with injected commas and slips", stim.size());
  endtask

  initial begin
    test_reset();
    test_idle();
    test_lock();
    test_slip();
    test_alt_disparity();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/deser_align.md
# deser_align

Serial-to-parallel front end of the receive path. Shifts the recovered serial bit stream in on CRCLK, finds the K28.5 comma at any bit offset, snaps the 10-bit word boundary to it and emits aligned 10-bit symbols plus a symbol strobe to the downstream K28.5 detector and 8b/10b decoder. A lock state machine with hysteresis decides when the boundary is trusted (`aligned`).

## Interface
- `LOCK_COMMAS`, 3: on-boundary commas, counting the realigning one, needed to reach LOCKED.
- `LOSS_COMMAS`, 2: consecutive off-boundary commas in LOCKED that force realignment.
- `CRCLK`  in  1: recovered bit clock, one serial bit per rising edge.
- `Reset_n`  in  1: reset; one clock; reset is asynchronous and active-low.
- `serial_in`  in  1: serial data. Bit `a` of each symbol is received first.
- `data_out`  out  10: last complete symbol. Bit `a` is at [9] and bit `j` is at [0].
- `word_strobe`  out  1: one-cycle pulse, high in the cycle `data_out` takes a new value.
- `comma_out`  out  1: the word in `data_out` is K28.5. Either disparity is accepted.
- `aligned`  out  1: high in LOCKED only.

## Operation
- Shift register `sr[9:0]`: `sr <= {sr[8:0], serial_in}` every cycle.
- Window `w = {sr[8:0], serial_in}` is combinational. `comma = (w == 10'b0011111010) | (w == 10'b1100000101)`.
- Bit counter `cnt` runs mod 10, 0..9. `boundary = (cnt == 9)`.
- When `boundary`, or on a realign:
  - `data_out <= w`
  - `comma_out <= comma`
  - `word_strobe <= 1`
  - In all other cycles `word_strobe <= 0`.
- Realign: `cnt <= 0`, which makes the current cycle the word boundary. Set `good_cnt <= 1` and `mis_cnt <= 0`.
- States:
  - HUNT (reset state):
    - `cnt` free-runs, so strobes keep firing at an arbitrary phase.
    - `comma` -> realign, go to CHECK. If `LOCK_COMMAS == 1`, go to LOCKED instead.
  - CHECK:
    - `boundary & comma` -> `good_cnt++`. Reaching `LOCK_COMMAS` -> LOCKED.
    - `comma & ~boundary` -> realign, stay in CHECK.
    - Boundary non-comma words are neutral.
  - LOCKED (`aligned = 1`):
    - `boundary & comma` -> `mis_cnt <= 0`.
    - `comma & ~boundary` -> `mis_cnt++`, with no realign.
    - When `mis_cnt` would reach `LOSS_COMMAS`: realign on that comma, go to CHECK, `aligned` falls.
    - Boundary non-comma words are neutral.
- Widths:
  - `cnt` is 4 bits.
  - `good_cnt` and `mis_cnt` are `$clog2(max(LOCK_COMMAS, LOSS_COMMAS) + 1)` bits and saturate at their thresholds.
- A realign strobe may follow the previous strobe after fewer than 10 cycles. Downstream accepts short words only while `aligned` is low.

## Timing
- All outputs are registered. Reset values:
  - `data_out = 0`, `word_strobe = 0`, `comma_out = 0`, `aligned = 0`.
  - `sr = 0`, `cnt = 0`, `good_cnt = 0`, `mis_cnt = 0`, state HUNT.
- Latency: the edge that samples bit `j` also updates `data_out`, `comma_out` and `word_strobe`. They are visible in the following cycle, which is 1 cycle after the last bit.
- Once aligned, `data_out` is stable for exactly 10 cycles between strobes.
- `aligned` rises on the same edge that latches the `LOCK_COMMAS`-th boundary comma. It falls on the same edge as the loss-triggered realign strobe.
- Reset asserted mid-word: outputs clear immediately. After release, the first strobe comes 10 cycles later, because `cnt` starts at 0.
- Simultaneous boundary and comma in HUNT: treat it as a realign. This gives the same result as a normal boundary with `cnt <= 0`.

## Structure
- Shared package `rx_pkg` holds:
  - `K285_RDN = 10'b0011111010`
  - `K285_RDP = 10'b1100000101`
  - `SYM_W = 10`
  - the `align_state_t` enum: HUNT, CHECK, LOCKED.
- One sub-module `comma_match`: combinational 10-bit window to 1-bit match. It is reused by the downstream symbol stage.
- The lock FSM and counters live in `deser_align`.

## Test plan
- Reset release, idle zeros for 40 bits -> `word_strobe` every 10 cycles. `data_out = 0`, `comma_out = 0`, `aligned = 0`.
- 3 bits of junk, then K28.5 RD- (0011111010) followed by D-words and two more K28.5 at 10-bit spacing:
  - strobe with `data_out = 10'h0FA` and `comma_out = 1`, 1 cycle after the first comma's last bit;
  - `aligned` rises with the third comma.
- Locked stream with one bit slipped, placing a single comma off-boundary -> `aligned` stays 1 and no realign happens. A second consecutive off-boundary comma -> realign strobe, `aligned = 0`, state CHECK.
- Alternating RD+ (1100000101, `10'h305`) and RD- commas -> both flagged. Lock after 3 commas.
- `Reset_n` pulsed low mid-word while locked -> all outputs 0 asynchronously, before the next CRCLK edge. HUNT resumes after release.
- `LOCK_COMMAS = 1` build: the first comma sets `aligned` on the realign edge.
